toggle_event_rx: RTL and testbench

Receiving end of the team's single-wire toggle-event link. The transmitter is a T flip-flop whose `q` changes level once per event. This block samples that line on its own clock and synchronises it. Each level change becomes one event, held in a saturating pending counter and released downstream through a valid/ready handshake. It also keeps a local mirror of the remote flip-flop state (`tog_q`/`tog_nq`) and flags any events dropped because the counter was full.

---
 rtl/toggle_event_rx.sv | 70 +++++++
 tb/tb_toggle_event_rx.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/toggle_event_rx.sv
// Receiver for the single-wire toggle-event link: synchronises the remote T flip-flop
// level, turns each level change into an event and hands events out over valid/ready.
module toggle_event_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tog_in,
    input  logic             evt_ready,
    input  logic             ovf_clr,
    output logic             evt_valid,
    output logic [CNT_W-1:0] pending,
    output logic             overflow,
    output logic             tog_q,
    output logic             tog_nq
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync;
    logic                   det;
    logic                   accept;
    logic                   drop;
    logic [CNT_W-1:0]       pending_nxt;
    logic                   overflow_nxt;

    assign sync      = sync_ff[SYNC_STAGES-1];
    assign det       = sync ^ tog_q;
    assign evt_valid = (pending != '0);
    assign accept    = evt_valid & evt_ready;
    assign tog_nq    = ~tog_q;

    // A simultaneous detect and accept cancels out, so nothing is dropped even when full.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        pending_nxt  = pending;
        drop         = 1'b0;
        unique case ({det, accept})
            2'b10: begin
                if (pending == CNT_MAX) drop = 1'b1;
                else                    pending_nxt = pending + CNT_ONE;
            end
            2'b01:   pending_nxt = pending - CNT_ONE;
            default: pending_nxt = pending;
        endcase
        // A drop in the same cycle as a clear must keep the flag set.
        if (drop)         overflow_nxt = 1'b1;
        else if (ovf_clr) overflow_nxt = 1'b0;
        else              overflow_nxt = overflow;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff  <= '0;
            tog_q    <= 1'b0;
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            sync_ff  <= {sync_ff[SYNC_STAGES-2:0], tog_in};
            tog_q    <= sync;
            pending  <= pending_nxt;
            overflow <= overflow_nxt;
        end
    end

endmodule

// File: tb/tb_toggle_event_rx.sv
// Self-checking bench for toggle_event_rx: vector table plus hand sequences for
// saturation, overflow clear, mid-operation reset and streaming.
module tb_toggle_event_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tog_in;
    logic       evt_ready;
    logic       ovf_clr;
    logic       evt_valid;
    logic [3:0] pending;
    logic       overflow;
    logic       tog_q;
    logic       tog_nq;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       tin;
        logic       rdy;
        logic       clr;
        logic [3:0] p;
        logic       v;
        logic       o;
        logic       q;
    } vec_t;

    typedef struct {
        logic [3:0] p;
        logic       v;
        logic       o;
        logic       q;
        string      nm;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[19];

    toggle_event_rx #(.SYNC_STAGES(2), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tog_in    (tog_in),
        .evt_ready (evt_ready),
        .ovf_clr   (ovf_clr),
        .evt_valid (evt_valid),
        .pending   (pending),
        .overflow  (overflow),
        .tog_q     (tog_q),
        .tog_nq    (tog_nq)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
        end
    endtask

    // Drive one cycle of inputs, queue the expected post-edge state, then compare.
    task automatic cyc(input logic tin, input logic rdy, input logic clr,
                       input logic [3:0] ep, input logic ev, input logic eo,
                       input logic eq, input string nm);
        exp_t e;
        @(negedge clk);
        tog_in    = tin;
        evt_ready = rdy;
        ovf_clr   = clr;
        e.p = ep; e.v = ev; e.o = eo; e.q = eq; e.nm = nm;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({e.nm, ".pending"},   32'(pending),   32'(e.p));
        check({e.nm, ".evt_valid"}, 32'(evt_valid), 32'(e.v));
        check({e.nm, ".overflow"},  32'(overflow),  32'(e.o));
        check({e.nm, ".tog_q"},     32'(tog_q),     32'(e.q));
        check({e.nm, ".tog_nq"},    32'(tog_nq),    32'(!e.q));
    endtask

    task automatic drive(input logic tin, input logic rdy);
        @(negedge clk);
        tog_in    = tin;
        evt_ready = rdy;
        ovf_clr   = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string nm);
        check({nm, ".pending"},   32'(pending),   0);
        check({nm, ".evt_valid"}, 32'(evt_valid), 0);
        check({nm, ".overflow"},  32'(overflow),  0);
        check({nm, ".tog_q"},     32'(tog_q),     0);
        check({nm, ".tog_nq"},    32'(tog_nq),    1);
    endtask

    initial begin
        int acc;
        int maxp;
        logic lvl;

        //        tin  rdy  clr   p   v  o  q
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0}; // quiet after release
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0}; // E0
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0}; // E1
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b1}; // E2: event counted
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1}; // accept
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1}; // ready with nothing pending
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0, 1'b1}; // detect + accept at 1
        tbl[13] = '{1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1};
        for (int i = 14; i < 19; i++)
            tbl[i] = '{1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1}; // underflow guard

        rst_n     = 1'b0;
        tog_in    = 1'b0;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        #3;
        check_reset("reset_initial");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++)
            cyc(tbl[i].tin, tbl[i].rdy, tbl[i].clr, tbl[i].p, tbl[i].v, tbl[i].o, tbl[i].q,
                $sformatf("vec%0d", i));

        // Saturation: 17 toggles, 2 cycles per level, nobody accepting.
        lvl = 1'b1;
        for (int i = 0; i < 17; i++) begin
            lvl = ~lvl;
            drive(lvl, 1'b0);
            drive(lvl, 1'b0);
        end
        for (int i = 0; i < 3; i++) drive(lvl, 1'b0);
        check("sat.pending",  32'(pending),  15);
        check("sat.overflow", 32'(overflow), 1);

        cyc(1'b0, 1'b0, 1'b1, 4'd15, 1'b1, 1'b0, 1'b0, "ovf_clr");
        cyc(1'b1, 1'b0, 1'b0, 4'd15, 1'b1, 1'b0, 1'b0, "max_e0");
        cyc(1'b1, 1'b0, 1'b0, 4'd15, 1'b1, 1'b0, 1'b0, "max_e1");
        cyc(1'b1, 1'b1, 1'b0, 4'd15, 1'b1, 1'b0, 1'b1, "det_acc_at_max");
        cyc(1'b0, 1'b0, 1'b0, 4'd15, 1'b1, 1'b0, 1'b1, "drop_e0");
        cyc(1'b0, 1'b0, 1'b0, 4'd15, 1'b1, 1'b0, 1'b1, "drop_e1");
        cyc(1'b0, 1'b0, 1'b1, 4'd15, 1'b1, 1'b1, 1'b0, "drop_with_clr");

        for (int i = 0; i < 10; i++)
            cyc(1'b0, 1'b1, 1'b0, 4'(14 - i), 1'b1, 1'b1, 1'b0, $sformatf("drain%0d", i));

        // Asynchronous reset mid-cycle with pending = 5 and overflow set.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("reset_mid");
        evt_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++)
            cyc(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, $sformatf("post_reset%0d", i));

        // Streaming: ready held high, 20 toggles at 2 cycles per level.
        acc  = 0;
        maxp = 0;
        for (int k = 0; k < 46; k++) begin
            drive((k < 40) ? (((k / 2) % 2) == 0) : 1'b0, 1'b1);
            if (evt_valid) acc++;
            if (int'(pending) > maxp) maxp = int'(pending);
        end
        check("stream.accepts",     32'(acc),               20);
        check("stream.max_le_1",    32'(maxp <= 1),         1);
        check("stream.tog_q",       32'(tog_q),             0);
        check("stream.pending_end", 32'(pending),           0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
